// File: rtl/lram_pkg.sv
// Shared constants and types for the 8x8 distributed-RAM FIFO slice.
package lram_pkg;
  localparam int LRAM_DW    = 8;
  localparam int LRAM_AW    = 3;
  localparam int LRAM_DEPTH = 8;

  typedef logic [LRAM_AW-1:0] lram_addr_t;
  typedef logic [LRAM_DW-1:0] lram_data_t;
  typedef logic [LRAM_AW:0]   lram_cnt_t;
endpackage

// File: rtl/lram_fifo_ctrl_if.sv
// Stream-in, stream-out and RAM-port bundle of the FIFO controller.
// The master side is the controller; the slave side is whoever drives it.
interface lram_fifo_ctrl_if;
  import lram_pkg::*;

  logic       in_valid;
  lram_data_t in_data;
  logic       in_ready;
  logic       out_valid;
  lram_data_t out_data;
  logic       out_ready;
  lram_addr_t ram_addr;
  lram_data_t ram_data;
  logic       ram_wen;
  lram_data_t ram_q;
  lram_cnt_t  count;

  modport master (
    input  in_valid, in_data, out_ready, ram_q,
    output in_ready, out_valid, out_data, ram_addr, ram_data, ram_wen, count
  );

  modport slave (
    output in_valid, in_data, out_ready, ram_q,
    input  in_ready, out_valid, out_data, ram_addr, ram_data, ram_wen, count
  );
endinterface

// File: rtl/lram_fifo.sv
// Integration wrapper: FIFO controller wired to the RAM stage; 9-byte FIFO overall.
module lram_fifo
  import lram_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  input  lram_data_t in_data,
  output logic       in_ready,
  output logic       out_valid,
  output lram_data_t out_data,
  input  logic       out_ready,
  output lram_cnt_t  count
);

  lram_fifo_ctrl_if bus ();

  assign bus.in_valid  = in_valid;
  assign bus.in_data   = in_data;
  assign bus.out_ready = out_ready;
  assign in_ready      = bus.in_ready;
  assign out_valid     = bus.out_valid;
  assign out_data      = bus.out_data;
  assign count         = bus.count;

  lram_fifo_ctrl u_ctrl (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  main u_ram (
    .clock (clock),
    .addr  (bus.ram_addr),
    .data  (bus.ram_data),
    .wen   (bus.ram_wen),
    .y     (bus.ram_q)
  );

endmodule

// File: rtl/main.sv
// 8x8 distributed-RAM stage: synchronous write, asynchronous read at one shared address.
module main
  import lram_pkg::*;
(
  input  logic       clock,
  input  lram_addr_t addr,
  input  lram_data_t data,
  input  logic       wen,
  output lram_data_t y
);

  lram_data_t mem_q [LRAM_DEPTH];

  always_ff @(posedge clock) begin
    if (wen) begin
      mem_q[addr] <= data;
    end
  end

  assign y = mem_q[addr];

endmodule

// File: rtl/lram_fifo_ctrl.sv
// FIFO controller around a single-address async-read RAM plus one output register.
// Each cycle is exactly one of read, write, bypass or idle because the RAM has one address.
module lram_fifo_ctrl
  import lram_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  lram_fifo_ctrl_if.master bus
);

  localparam lram_cnt_t  CNT_FULL = lram_cnt_t'(LRAM_DEPTH);
  localparam lram_cnt_t  CNT_ONE  = lram_cnt_t'(1);
  localparam lram_addr_t PTR_ONE  = lram_addr_t'(1);

  lram_addr_t wptr_q, wptr_d;
  lram_addr_t rptr_q, rptr_d;
  lram_cnt_t  count_q, count_d;
  logic       out_valid_q, out_valid_d;
  lram_data_t out_data_q, out_data_d;

  logic pop, slot_free, ram_empty, rd, byp, wr, in_ready;

  // A read refilling the output slot owns the RAM address, so it blocks writes.
  always_comb begin
    pop       = out_valid_q & bus.out_ready;
    slot_free = !out_valid_q | pop;
    ram_empty = (count_q == '0);
    rd        = slot_free & !ram_empty;
    byp       = slot_free & ram_empty & bus.in_valid;
    in_ready  = !reset & ((slot_free & ram_empty) | (!rd & (count_q != CNT_FULL)));
    wr        = bus.in_valid & in_ready & !byp;
  end

  assign bus.in_ready  = in_ready;
  assign bus.ram_addr  = rd ? rptr_q : wptr_q;
  assign bus.ram_wen   = wr & !reset;
  assign bus.ram_data  = bus.in_data;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.count     = count_q;

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (rd) begin
      out_data_d  = bus.ram_q;
      out_valid_d = 1'b1;
      rptr_d      = rptr_q + PTR_ONE;
      count_d     = count_q - CNT_ONE;
    end else if (byp) begin
      out_data_d  = bus.in_data;
      out_valid_d = 1'b1;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end

    if (wr) begin
      wptr_d  = wptr_q + PTR_ONE;
      count_d = count_q + CNT_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_lram_fifo_ctrl.sv
// Bench for lram_fifo_ctrl: queue-based reference model checked every cycle plus directed literal checks.
module tb_lram_fifo_ctrl;
  import lram_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  lram_fifo_ctrl_if bus ();

  lram_fifo_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // RAM stage model: async read, write on the controller's clock edge
  logic [7:0] ram [8];
  assign bus.ram_q = ram[bus.ram_addr];
  always @(posedge clock) if (bus.ram_wen) ram[bus.ram_addr] <= bus.ram_data;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: output slot plus a queue of bytes sitting in RAM
  bit         m_init = 0;
  bit         m_ov;
  logic [7:0] m_od;
  logic [7:0] m_ram [$];
  int         m_wr, m_rd;
  logic [7:0] sb [$];
  logic [7:0] popped [$];
  int         wen_cnt = 0, wwrap = 0, rwrap = 0;
  int         last_waddr = 0, last_raddr = 0;

  always @(negedge clock) begin
    bit free, rdm, bypm, acc_ok, acc, wrm;
    if (reset) begin
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_ram_wen", bus.ram_wen, 0);
      m_ov = 0; m_od = '0; m_ram.delete(); sb.delete();
      m_wr = 0; m_rd = 0; m_init = 1;
    end else if (m_init) begin
      free   = !m_ov || bus.out_ready;
      rdm    = free && (m_ram.size() > 0);
      bypm   = free && (m_ram.size() == 0) && bus.in_valid;
      acc_ok = (free && m_ram.size() == 0) || (!rdm && m_ram.size() < 8);
      acc    = bus.in_valid && acc_ok;
      wrm    = acc && !bypm;
      chk("in_ready", bus.in_ready, acc_ok);
      chk("out_valid", bus.out_valid, m_ov);
      chk("count", bus.count, m_ram.size());
      chk("ram_wen", bus.ram_wen, wrm);
      if (m_ov) chk("out_data", bus.out_data, m_od);
      if (rdm) chk("ram_addr_rd", bus.ram_addr, m_rd % 8);
      else if (wrm) begin
        chk("ram_addr_wr", bus.ram_addr, m_wr % 8);
        chk("ram_data", bus.ram_data, bus.in_data);
      end
      if (m_ov && bus.out_ready) begin
        popped.push_back(bus.out_data);
        chk("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) chk("order", bus.out_data, sb.pop_front());
      end
      if (bus.ram_wen) begin
        wen_cnt++;
        if (bus.ram_addr == 0 && last_waddr == 7) wwrap++;
        last_waddr = bus.ram_addr;
      end
      if (rdm) begin
        if (bus.ram_addr == 0 && last_raddr == 7) rwrap++;
        last_raddr = bus.ram_addr;
      end
      if (acc) sb.push_back(bus.in_data);
      if (rdm) begin
        m_od = m_ram.pop_front(); m_ov = 1; m_rd++;
      end else if (bypm) begin
        m_od = bus.in_data; m_ov = 1;
      end else if (m_ov && bus.out_ready) begin
        m_ov = 0;
      end
      if (wrm) begin
        m_ram.push_back(bus.in_data); m_wr++;
      end
    end
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  // Offer a byte until accepted, bounded by a cycle budget
  task automatic push(input logic [7:0] d, input int budget);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int k = 0; k < budget; k++) begin
      @(negedge clock);
      if (bus.in_ready) begin
        step();
        bus.in_valid = 1'b0;
        return;
      end
      step();
    end
    n_cmp++; n_bad++;
    $display("FAIL push_timeout: byte 0x%0h not accepted within %0d cycles", d, budget);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) ram[i] = '0;

    step(); step();
    reset = 1'b0;
    @(negedge clock);
    chk("init_count", bus.count, 0);
    chk("init_out_valid", bus.out_valid, 0);
    chk("init_out_data", bus.out_data, 0);
    step();

    // Bypass streaming
    popped.delete();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h10 + 8'(i);
      step();
    end
    bus.in_valid = 1'b0;
    step(); step();
    chk("byp_no_wen", wen_cnt, 0);
    chk("byp_npop", popped.size(), 16);
    for (int i = 0; i < 16; i++)
      if (i < popped.size()) chk("byp_seq", popped[i], 8'h10 + 8'(i));

    // Fill to full
    popped.delete();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 9; i++) push(8'hA0 + 8'(i), 5);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA9;
    step(); step();
    @(negedge clock);
    chk("full_count", bus.count, 8);
    chk("full_in_ready", bus.in_ready, 0);
    chk("full_out_data", bus.out_data, 8'hA0);
    for (int i = 0; i < 8; i++) chk("full_ram", ram[i], 8'hA1 + 8'(i));
    step();

    // Drain from full; 0xA9 still offered
    bus.out_ready = 1'b1;
    push(8'hA9, 20);
    repeat (3) step();
    chk("drain_npop", popped.size(), 10);
    for (int i = 0; i < 10; i++)
      if (i < popped.size()) chk("drain_seq", popped[i], 8'hA0 + 8'(i));

    // Simultaneous pop and push
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'h30 + 8'(i), 5);
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h34;
    bus.out_ready = 1'b1;
    @(negedge clock);
    chk("sim3_count", bus.count, 3);
    chk("sim3_in_ready", bus.in_ready, 0);
    step();
    bus.in_valid = 1'b0;
    step(); step();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h35;
    @(negedge clock);
    chk("sim0_count", bus.count, 0);
    chk("sim0_out_valid", bus.out_valid, 1);
    chk("sim0_in_ready", bus.in_ready, 1);
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clock);
    chk("sim0_byp_valid", bus.out_valid, 1);
    chk("sim0_byp_data", bus.out_data, 8'h35);
    step();

    // Randomised traffic with wrap-around
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = 8'($urandom);
      bus.out_ready = ($urandom_range(0, 1) != 0);
      step();
    end
    chk("wptr_wrapped", wwrap >= 2, 1);
    chk("rptr_wrapped", rwrap >= 2, 1);

    // Reset mid-stream at count 5
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (12) step();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'h60 + 8'(i), 5);
    @(negedge clock);
    chk("pre_rst_count", bus.count, 5);
    step();
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    @(negedge clock);
    chk("mid_rst_in_ready", bus.in_ready, 0);
    chk("mid_rst_ram_wen", bus.ram_wen, 0);
    step();
    @(negedge clock);
    chk("mid_rst_count", bus.count, 0);
    chk("mid_rst_out_valid", bus.out_valid, 0);
    step();
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    popped.delete();
    @(negedge clock);
    chk("post_rst_out_valid", bus.out_valid, 0);
    chk("post_rst_count", bus.count, 0);
    step();
    push(8'h88, 5);
    repeat (4) step();
    chk("post_rst_npop", popped.size(), 1);
    if (popped.size() > 0) chk("post_rst_data", popped[0], 8'h88);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
